bin2seg_scan: RTL

Sequential successor to the single-digit 7-segment decoder. It converts a WIDTH-bit unsigned binary value to DIGITS BCD digits with a serial shift-add-3 (double-dabble) engine. It then drives a time-multiplexed common-anode/cathode display, one digit at a time, with leading-zero blanking and overflow indication. It sits between datapath counters/registers and the board's 7-segment pins.

---
 rtl/bin2seg_scan.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/bin2seg_scan.sv
`default_nettype none
// ============================================================================
//  Module   : bin2seg_scan
//  Purpose  : Serial binary-to-BCD converter (shift-add-3) feeding a
//             time-multiplexed 7-segment display. Features leading-zero
//             blanking and a dash display when the value does not fit.
//  Ports    : clk, rst        - clock, synchronous active-high reset
//             bin_in, load    - value to convert and start request
//             busy, done      - conversion running / one-cycle result pulse
//             overflow        - last converted value >= 10^DIGITS
//             seg[6:0]        - segments a..g (seg[6]=a)
//             an[DIGITS-1:0]  - one-hot digit select, an[0] = units
//  Revision : 1.0 - initial release
// ============================================================================
module bin2seg_scan #(
  parameter int WIDTH         = 8,
  parameter int DIGITS        = 3,
  parameter int SCAN_DIV      = 50000,
  parameter int ACTIVE_LOW    = 1,
  parameter int BLANK_LEADING = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  bin_in,
  input  logic              load,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic [6:0]        seg,
  output logic [DIGITS-1:0] an
);

  localparam int NIBS   = DIGITS + 4;
  localparam int BCD_W  = 4 * NIBS;
  localparam int DISP_W = 4 * DIGITS;
  localparam int CNT_W  = $clog2(WIDTH + 1);
  localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DIG_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) r = r * 64'd10;
    return r;
  endfunction

  localparam logic [63:0]       LIMIT     = pow10(DIGITS);
  localparam logic [CNT_W-1:0]  CNT_INIT  = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
  localparam logic [DIG_W-1:0]  DIG_LAST  = DIG_W'(DIGITS - 1);
  localparam logic [DIG_W-1:0]  DIG_ONE   = DIG_W'(1);
  localparam logic [DIGITS-1:0] AN_ONE    = DIGITS'(1);
  localparam logic [6:0]        SEG_DASH  = 7'b1111110;
  localparam logic [6:0]        SEG_BLANK = 7'b1111111;
  localparam logic [6:0]        SEG_RST   = (ACTIVE_LOW != 0) ? 7'b0000001 : 7'b1111110;
  localparam logic [DIGITS-1:0] AN_RST    = (ACTIVE_LOW != 0) ? ~AN_ONE : AN_ONE;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_SHIFT = 2'd1, S_LATCH = 2'd2} state_t;

  // Active-low a..g patterns for decimal digits.
  function automatic logic [6:0] dec7(input logic [3:0] v);
    case (v)
      4'd0:    dec7 = 7'b0000001;
      4'd1:    dec7 = 7'b1001111;
      4'd2:    dec7 = 7'b0010010;
      4'd3:    dec7 = 7'b0000110;
      4'd4:    dec7 = 7'b1001100;
      4'd5:    dec7 = 7'b0100100;
      4'd6:    dec7 = 7'b0100000;
      4'd7:    dec7 = 7'b0001111;
      4'd8:    dec7 = 7'b0000000;
      4'd9:    dec7 = 7'b0000100;
      default: dec7 = SEG_BLANK;
    endcase
  endfunction

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0]    bin_q, bin_d;
  logic [BCD_W-1:0]    bcd_q, bcd_d, adj;
  logic                busy_q, busy_d, done_q, done_d;
  logic                ovf_pend_q, ovf_pend_d, ovf_q, ovf_d;
  logic [DISP_W-1:0]   disp_q, disp_d;
  logic [SCAN_W-1:0]   scan_q, scan_d;
  logic [DIG_W-1:0]    dig_q, dig_d;
  logic [6:0]          seg_q, seg_d, raw;
  logic [DIGITS-1:0]   an_q, an_d, an_hot, blank;
  logic [3:0]          nib;
  logic                all_zero;

  // Conversion FSM and datapath next state.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bin_d      = bin_q;
    bcd_d      = bcd_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    ovf_pend_d = ovf_pend_q;
    ovf_d      = ovf_q;
    disp_d     = disp_q;

    adj = bcd_q;
    for (int i = 0; i < NIBS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end

    case (state_q)
      S_IDLE: begin
        if (load) begin
          state_d    = S_SHIFT;
          bin_d      = bin_in;
          bcd_d      = '0;
          cnt_d      = CNT_INIT;
          busy_d     = 1'b1;
          // Overflow is decided on the captured binary value, so it stays
          // correct even when the working BCD is too narrow for all digits.
          ovf_pend_d = (64'(bin_in) >= LIMIT);
        end
      end
      S_SHIFT: begin
        bcd_d = (adj << 1) | BCD_W'(bin_q[WIDTH-1]);
        bin_d = bin_q << 1;
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) state_d = S_LATCH;
      end
      S_LATCH: begin
        disp_d  = bcd_q[DISP_W-1:0];
        ovf_d   = ovf_pend_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Scan index and registered digit drive. seg/an are computed from the
  // next-state display and index so they switch on the same edge.
  always_comb begin
    scan_d = scan_q + SCAN_W'(1);
    dig_d  = dig_q;
    if (scan_q == SCAN_LAST) begin
      scan_d = '0;
      dig_d  = (dig_q == DIG_LAST) ? '0 : dig_q + DIG_ONE;
    end

    all_zero = 1'b1;
    blank    = '0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      all_zero = all_zero & (disp_d[4*k +: 4] == 4'd0);
      if (k != 0 && BLANK_LEADING != 0) blank[k] = all_zero;
    end

    nib = disp_d[{dig_d, 2'b00} +: 4];
    if (ovf_d)              raw = SEG_DASH;
    else if (blank[dig_d])  raw = SEG_BLANK;
    else                    raw = dec7(nib);

    seg_d  = (ACTIVE_LOW != 0) ? raw : ~raw;
    an_hot = AN_ONE << dig_d;
    an_d   = (ACTIVE_LOW != 0) ? ~an_hot : an_hot;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      bin_q      <= '0;
      bcd_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ovf_pend_q <= 1'b0;
      ovf_q      <= 1'b0;
      disp_q     <= '0;
      scan_q     <= '0;
      dig_q      <= '0;
      seg_q      <= SEG_RST;
      an_q       <= AN_RST;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bin_q      <= bin_d;
      bcd_q      <= bcd_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ovf_pend_q <= ovf_pend_d;
      ovf_q      <= ovf_d;
      disp_q     <= disp_d;
      scan_q     <= scan_d;
      dig_q      <= dig_d;
      seg_q      <= seg_d;
      an_q       <= an_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign overflow = ovf_q;
  assign seg      = seg_q;
  assign an       = an_q;

endmodule
`default_nettype wire
